// File: rtl/id_scroll_controller_if.sv
// ROM-side and display-side signals of the ID scroll sequencer.
// The slave modport is the controller; the master modport is the ROM/display side.
interface id_scroll_controller_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        digit;
  logic              digit_valid;
  logic [1:0]        state;
  logic              tick;

  modport master (
    input  rom_addr, digit, digit_valid, state, tick,
    output rom_data
  );

  modport slave (
    output rom_addr, digit, digit_valid, state, tick,
    input  rom_data
  );
endinterface

// File: rtl/id_scroll_controller.sv
// Single-clock sequencer for the student-ID display: walks the ROM address with
// pause/resume and single-step driven by two debounced active-low pushbuttons.
module id_scroll_controller #(
  parameter int ADDR_W     = 3,
  parameter int LAST_ADDR  = 7,
  parameter int TICK_DIV   = 25_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic                  clk_50M,
  input  logic                  reset,
  input  logic                  btn_pause,
  input  logic                  btn_step,
  id_scroll_controller_if.slave bus
);
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam int PRE_W = $clog2(TICK_DIV);

  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_STEP  = 2'b11;

  logic [1:0] btn_raw;
  logic [1:0] press_evt;
  logic       pause_evt;
  logic       step_evt;

  assign btn_raw   = {btn_step, btn_pause};
  assign pause_evt = press_evt[0];
  assign step_evt  = press_evt[1];

  // Index 0 is the pause button, index 1 the step button.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_q, sync2_q;
      logic             deb_q, deb_d;
      logic             evt_q, evt_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
          if (cnt_q + CNT_W'(1) == CNT_W'(DEB_CYCLES)) begin
            deb_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Pulse only on the accepted press (1->0); release is silent.
        evt_d = deb_q & ~deb_d;
      end

      always_ff @(posedge clk_50M) begin
        if (reset) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          deb_q   <= 1'b1;
          cnt_q   <= '0;
          evt_q   <= 1'b0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          deb_q   <= deb_d;
          cnt_q   <= cnt_d;
          evt_q   <= evt_d;
        end
      end

      assign press_evt[gi] = evt_q;
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        digit_q;
  logic              digit_valid_q;
  logic              tick;
  logic              advance;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (pause_evt) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (pause_evt)     state_d = ST_RUN;
        else if (step_evt) state_d = ST_STEP;
      end
      ST_STEP:  state_d = ST_PAUSE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    tick    = (state_q == ST_RUN) && (presc_q == PRE_W'(TICK_DIV - 1));
    advance = tick || (state_q == ST_STEP);
  end

  // Prescaler parks at 0 outside RUN so resume waits a full period.
  always_comb begin
    presc_d = '0;
    if (state_q == ST_RUN && !tick) begin
      presc_d = presc_q + PRE_W'(1);
    end
    rom_addr_d = rom_addr_q;
    if (advance) begin
      rom_addr_d = (rom_addr_q == ADDR_W'(LAST_ADDR)) ? '0 : rom_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      presc_q       <= '0;
      rom_addr_q    <= '0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      rom_addr_q    <= rom_addr_d;
      digit_q       <= bus.rom_data;
      digit_valid_q <= 1'b1;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.digit       = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.state       = state_q;
  assign bus.tick        = tick;
endmodule

// File: tb/tb_id_scroll_controller.sv
// Directed bench for id_scroll_controller with TICK_DIV=4, DEB_CYCLES=3 and an
// 8-entry ROM; k counts clock edges since reset was released.
module tb_id_scroll_controller;
  logic clk = 1'b0;
  logic reset;
  logic btn_pause;
  logic btn_step;
  int   k;
  int   vectors = 0;
  int   errors  = 0;

  logic [3:0] rom_mem [8] = '{4'h2, 4'h0, 4'h1, 4'h9, 4'h5, 4'h7, 4'h3, 4'h8};

  id_scroll_controller_if #(.ADDR_W(3)) bus ();

  assign bus.rom_data = rom_mem[bus.rom_addr];

  id_scroll_controller #(
    .ADDR_W    (3),
    .LAST_ADDR (7),
    .TICK_DIV  (4),
    .DEB_CYCLES(3)
  ) dut (
    .clk_50M  (clk),
    .reset    (reset),
    .btn_pause(btn_pause),
    .btn_step (btn_step),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @k=%0d: got %0h, expected %0h", tag, k, obs, exp);
    end else begin
      $display("ok   %s @k=%0d: %0h", tag, k, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // Press step in PAUSE: event 5 edges after driving, STEP the next edge, then PAUSE with addr+1.
  task automatic press_step(input int exp_addr);
    btn_step = 1'b0;
    step(6);
    check_eq("step_state_step", 32'(bus.state), 32'h3);
    step(1);
    check_eq("step_back_pause", 32'(bus.state), 32'h2);
    check_eq("step_addr", 32'(bus.rom_addr), exp_addr);
    btn_step = 1'b1;
    step(8);
    check_eq("step_hold_pause", 32'(bus.state), 32'h2);
    check_eq("step_digit", 32'(bus.digit), 32'(rom_mem[exp_addr]));
  endtask

  initial begin
    reset     = 1'b1;
    btn_pause = 1'b1;
    btn_step  = 1'b1;
    k         = 0;
    step(3);
    check_eq("rst_addr", 32'(bus.rom_addr), 0);
    check_eq("rst_digit", 32'(bus.digit), 0);
    check_eq("rst_valid", 32'(bus.digit_valid), 0);
    check_eq("rst_state", 32'(bus.state), 32'h1);
    check_eq("rst_tick", 32'(bus.tick), 0);

    // Free run: address steps every 4 edges and wraps 7 -> 0.
    reset = 1'b0;
    k     = 0;
    for (int i = 1; i <= 35; i++) begin
      step(1);
      check_eq("run_addr", 32'(bus.rom_addr), (i / 4) % 8);
      check_eq("run_tick", 32'(bus.tick), ((i % 4) == 3) ? 1 : 0);
      check_eq("run_digit", 32'(bus.digit), 32'(rom_mem[((i - 1) / 4) % 8]));
      check_eq("run_valid", 32'(bus.digit_valid), 1);
    end

    // Two-cycle glitch on pause is rejected.
    btn_pause = 1'b0;
    step(2);
    btn_pause = 1'b1;
    step(8);
    check_eq("glitch_state", 32'(bus.state), 32'h1);
    check_eq("glitch_addr", 32'(bus.rom_addr), 3);

    // Real pause press at k=45: still RUN at k=50, PAUSE at k=51.
    btn_pause = 1'b0;
    step(5);
    check_eq("pause_pre_state", 32'(bus.state), 32'h1);
    step(1);
    check_eq("pause_state", 32'(bus.state), 32'h2);
    check_eq("pause_addr", 32'(bus.rom_addr), 4);
    step(4);
    btn_pause = 1'b1;
    step(15);
    check_eq("release_state", 32'(bus.state), 32'h2);
    check_eq("frozen_addr", 32'(bus.rom_addr), 4);
    check_eq("pause_tick", 32'(bus.tick), 0);
    check_eq("frozen_digit", 32'(bus.digit), 32'(rom_mem[4]));

    // Single steps 4 -> 5 -> 6 -> 7 -> 0.
    press_step(5);
    press_step(6);
    press_step(7);
    press_step(0);

    // Both buttons together in PAUSE: resume wins, step dropped. r = edge of resume.
    btn_pause = 1'b0;
    btn_step  = 1'b0;
    step(6);
    check_eq("both_state", 32'(bus.state), 32'h1);
    check_eq("both_addr", 32'(bus.rom_addr), 0);
    step(1);
    check_eq("both_no_step", 32'(bus.state), 32'h1);
    check_eq("both_addr2", 32'(bus.rom_addr), 0);
    btn_pause = 1'b1;
    btn_step  = 1'b1;
    step(7);

    // Step press in RUN (r+8) is ignored.
    btn_step = 1'b0;
    step(6);
    check_eq("run_step_state", 32'(bus.state), 32'h1);
    check_eq("run_step_addr", 32'(bus.rom_addr), 3);
    step(1);
    btn_step = 1'b1;
    step(5);
    check_eq("run_step_state2", 32'(bus.state), 32'h1);
    check_eq("run_step_addr2", 32'(bus.rom_addr), 5);

    // Pause event lands on the tick cycle r+27: advance and pause together.
    step(2);
    btn_pause = 1'b0;
    step(5);
    check_eq("coinc_pre_state", 32'(bus.state), 32'h1);
    check_eq("coinc_tick", 32'(bus.tick), 1);
    check_eq("coinc_pre_addr", 32'(bus.rom_addr), 6);
    step(1);
    check_eq("coinc_state", 32'(bus.state), 32'h2);
    check_eq("coinc_addr", 32'(bus.rom_addr), 7);
    step(2);
    btn_pause = 1'b1;
    step(10);
    check_eq("coinc_hold_state", 32'(bus.state), 32'h2);
    check_eq("coinc_hold_addr", 32'(bus.rom_addr), 7);

    // Walk to address 5 in PAUSE, then reset.
    for (int e = 0; e <= 5; e++) begin
      press_step(e);
    end
    reset = 1'b1;
    step(1);
    check_eq("mid_rst_addr", 32'(bus.rom_addr), 0);
    check_eq("mid_rst_state", 32'(bus.state), 32'h1);
    check_eq("mid_rst_valid", 32'(bus.digit_valid), 0);
    check_eq("mid_rst_digit", 32'(bus.digit), 0);
    check_eq("mid_rst_tick", 32'(bus.tick), 0);
    reset = 1'b0;
    step(1);
    check_eq("post_rst_valid", 32'(bus.digit_valid), 1);
    check_eq("post_rst_state", 32'(bus.state), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
